hvsync_generator: RTL and testbench

//  Free-running raster timing generator for the 8-bit video pipeline. Counts pixel clocks (hpos)
//  and scanlines (vpos), decodes horizontal/vertical sync and the visible-area flag. Consumers
//  (sprite renderer, RAM update logic) key off hpos/vpos, e.g. "vpos==256", "vpos==260, hpos<256".

---
 rtl/video_timing_pkg.sv | 23 ++
 rtl/hvsync_generator.sv | 72 +++++++
 tb/tb_hvsync_generator.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Default raster timing for the 8-bit video pipeline and the coordinate type.
// Shared by the sync generator, the sprite renderer and the test tops.
package video_timing_pkg;

    typedef logic [8:0] coord_t;

    localparam int DEF_H_DISPLAY = 256;
    localparam int DEF_H_BACK    = 23;
    localparam int DEF_H_FRONT   = 7;
    localparam int DEF_H_SYNC    = 23;
    localparam int DEF_V_DISPLAY = 240;
    localparam int DEF_V_TOP     = 5;
    localparam int DEF_V_BOTTOM  = 14;
    localparam int DEF_V_SYNC    = 3;

    localparam int DEF_H_MAX        = DEF_H_DISPLAY + DEF_H_BACK + DEF_H_FRONT + DEF_H_SYNC - 1;
    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_MAX        = DEF_V_DISPLAY + DEF_V_TOP + DEF_V_BOTTOM + DEF_V_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_BOTTOM;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/hvsync_generator.sv
// Free-running raster counter with registered sync and visible-area decode.
// Decodes are taken from the next-state counters so they line up with hpos/vpos.
module hvsync_generator
    import video_timing_pkg::*;
#(
    parameter int H_DISPLAY       = DEF_H_DISPLAY,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int V_DISPLAY       = DEF_V_DISPLAY,
    parameter int V_TOP           = DEF_V_TOP,
    parameter int V_BOTTOM        = DEF_V_BOTTOM,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter bit SYNC_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on
);

    localparam int H_MAX_I = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
    localparam int V_MAX_I = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

    localparam coord_t H_MAX        = 9'(H_MAX_I);
    localparam coord_t H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t H_VISIBLE    = 9'(H_DISPLAY);
    localparam coord_t V_MAX        = 9'(V_MAX_I);
    localparam coord_t V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
    localparam coord_t V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam coord_t V_VISIBLE    = 9'(V_DISPLAY);

    // The counters have no overflow path of their own, so oversized timings are rejected here.
    generate
        if (H_MAX_I > 511 || V_MAX_I > 511) begin : g_range_check
            $error("hvsync_generator: H_MAX/V_MAX exceed the 9-bit counter range");
        end
    endgenerate

    coord_t h_next;
    coord_t v_next;

    always_comb begin
        h_next = hpos + 9'd1;
        v_next = vpos;
        if (hpos == H_MAX) begin
            h_next = '0;
            v_next = (vpos == V_MAX) ? '0 : vpos + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos       <= '0;
            vpos       <= '0;
            hsync      <= SYNC_ACTIVE_LOW;
            vsync      <= SYNC_ACTIVE_LOW;
            display_on <= 1'b0;
        end else begin
            hpos       <= h_next;
            vpos       <= v_next;
            hsync      <= ((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END)) ^ SYNC_ACTIVE_LOW;
            vsync      <= ((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END)) ^ SYNC_ACTIVE_LOW;
            display_on <= (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
        end
    end

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: one full frame against a reference raster model,
// an active-low-sync variant, and an asynchronous mid-frame reset.
module tb_hvsync_generator;

    typedef struct {
        logic [8:0] h;
        logic [8:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        bit         frame;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst_c;
    logic [8:0] hpos_a, vpos_a, hpos_b, vpos_b, hpos_c, vpos_c;
    logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b, hs_c, vs_c, de_c;

    int total = 0;
    int bad   = 0;
    int de_cnt = 0;
    int hs_line0_cnt = 0;
    int vs_cnt = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    hvsync_generator dut_a (
        .clk(clk), .reset(reset), .hpos(hpos_a), .vpos(vpos_a),
        .hsync(hs_a), .vsync(vs_a), .display_on(de_a)
    );

    hvsync_generator #(.SYNC_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset(reset), .hpos(hpos_b), .vpos(vpos_b),
        .hsync(hs_b), .vsync(vs_b), .display_on(de_b)
    );

    hvsync_generator dut_c (
        .clk(clk), .reset(rst_c), .hpos(hpos_c), .vpos(vpos_c),
        .hsync(hs_c), .vsync(vs_c), .display_on(de_c)
    );

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {h=%0d v=%0d hs=%b vs=%b de=%b} want {h=%0d v=%0d hs=%b vs=%b de=%b}",
                     name, act[20:12], act[11:3], act[2], act[1], act[0],
                     exp[20:12], exp[11:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: every clock presents a new raster sample, compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("a_edge%0d", e.idx), {hpos_a, vpos_a, hs_a, vs_a, de_a},
                      {e.h, e.v, e.hs, e.vs, e.de});
                check($sformatf("b_edge%0d", e.idx), {hpos_b, vpos_b, hs_b, vs_b, de_b},
                      {e.h, e.v, ~e.hs, ~e.vs, e.de});
                if (e.frame) begin
                    de_cnt += int'(de_a);
                    vs_cnt += int'(vs_a);
                    if (vpos_a == 9'd0) hs_line0_cnt += int'(hs_a);
                end
            end
        end
    end

    // Driver: reset, then one full frame of edges with the reference raster pushed per edge.
    initial begin
        exp_t e;
        logic [8:0] h, v;
        reset = 1'b0;
        rst_c = 1'b0;
        h = '0;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            e = '{h: 9'd0, v: 9'd0, hs: 1'b0, vs: 1'b0, de: 1'b0, frame: 1'b0, idx: -1};
            q.push_back(e);
        end
        @(negedge clk);
        reset = 1'b1;
        rst_c = 1'b1;

        for (int n = 1; n <= 80958; n++) begin
            @(posedge clk);
            if (h == 9'd308) begin
                h = 9'd0;
                v = (v == 9'd261) ? 9'd0 : v + 9'd1;
            end else begin
                h = h + 9'd1;
            end
            e.h     = h;
            e.v     = v;
            e.hs    = (h >= 9'd263) && (h <= 9'd285);
            e.vs    = (v >= 9'd254) && (v <= 9'd256);
            e.de    = (h < 9'd256) && (v < 9'd240);
            e.frame = 1'b1;
            e.idx   = n;
            q.push_back(e);

            // Edge 15550 lands on (100,50); reset dut_c between edges and expect an immediate clear.
            if (n == 15550) begin
                #2;
                check("c_pre_reset", {hpos_c, vpos_c, hs_c, vs_c, de_c}, {9'd100, 9'd50, 3'b001});
                rst_c = 1'b0;
                #1;
                check("c_async_reset", {hpos_c, vpos_c, hs_c, vs_c, de_c}, {9'd0, 9'd0, 3'b000});
            end
            if (n == 15552) begin
                #1;
                check("c_reset_held", {hpos_c, vpos_c, hs_c, vs_c, de_c}, {9'd0, 9'd0, 3'b000});
            end
        end

        @(negedge clk);
        #1;
        check_int("queue_drained", q.size(), 0);
        check_int("display_on_cycles", de_cnt, 61440);
        check_int("hsync_line0_cycles", hs_line0_cnt, 23);
        check_int("vsync_cycles", vs_cnt, 3 * 309);
        check("frame_end_a", {hpos_a, vpos_a, hs_a, vs_a, de_a}, {9'd0, 9'd0, 3'b001});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
